// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction fetch stage:
// FSM state encodings, bus widths and the zero word.
package inst_fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    function automatic logic word_aligned(input logic [ADDR_W-1:0] a);
        return a[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding ibus request at a time,
// a one-word hold buffer for stalls, flush discard, misaligned fetch.
// Ports: clk, rst (async active-low); pc/ce from PC reg, stall/flush
// from CTRL; ibus_req/addr/ack/rdata bus; pc_read_ready advances PC;
// if_pc/if_inst/if_valid/if_excpt_adel present the fetched slot.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ce,
    input  logic              stall,
    input  logic              flush,
    output logic              pc_read_ready,
    output logic              ibus_req,
    output logic [ADDR_W-1:0] ibus_addr,
    input  logic              ibus_ack,
    input  logic [DATA_W-1:0] ibus_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_valid,
    output logic              if_excpt_adel
);

    logic [1:0]        state;
    logic [DATA_W-1:0] hold_buf;
    logic              start;

    assign start = ce && !stall;

    always_comb begin
        pc_read_ready = 1'b0;
        if (rst && !flush) begin
            if (state == S_REQ && ibus_ack)
                pc_read_ready = 1'b1;
            else if (state == S_IDLE && start && !word_aligned(pc))
                pc_read_ready = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            ibus_req      <= 1'b0;
            ibus_addr     <= '0;
            if_pc         <= '0;
            if_inst       <= ZERO_WORD;
            if_valid      <= 1'b0;
            if_excpt_adel <= 1'b0;
            hold_buf      <= ZERO_WORD;
        end else begin
            // Slot expires unless stalled or refilled below.
            if (!stall) begin
                if_valid      <= 1'b0;
                if_excpt_adel <= 1'b0;
            end
            if (flush) begin
                if_valid      <= 1'b0;
                if_excpt_adel <= 1'b0;
                hold_buf      <= ZERO_WORD;
                // A pending bus cycle must still complete; its word is dropped.
                if (state == S_REQ || state == S_DISCARD) begin
                    if (ibus_ack) begin
                        ibus_req <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        state    <= S_DISCARD;
                    end
                end else begin
                    state <= S_IDLE;
                end
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (word_aligned(pc)) begin
                                ibus_req  <= 1'b1;
                                ibus_addr <= pc;
                                state     <= S_REQ;
                            end else begin
                                if_valid      <= 1'b1;
                                if_excpt_adel <= 1'b1;
                                if_pc         <= pc;
                                if_inst       <= ZERO_WORD;
                            end
                        end
                    end
                    S_REQ: begin
                        if (ibus_ack) begin
                            ibus_req <= 1'b0;
                            if (!stall) begin
                                if_valid <= 1'b1;
                                if_pc    <= ibus_addr;
                                if_inst  <= ibus_rdata;
                                state    <= S_IDLE;
                            end else begin
                                hold_buf <= ibus_rdata;
                                state    <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        // ibus_addr is untouched in HOLD, so it still names the word.
                        if (!stall) begin
                            if_valid <= 1'b1;
                            if_pc    <= ibus_addr;
                            if_inst  <= hold_buf;
                            hold_buf <= ZERO_WORD;
                            state    <= S_IDLE;
                        end
                    end
                    S_DISCARD: begin
                        if (ibus_ack) begin
                            ibus_req <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: bus responder, output monitor
// and directed fetch/stall/flush/misalign/reset sequences.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic        ce = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        pc_read_ready;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack = 1'b0;
    logic [31:0] ibus_rdata = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_excpt_adel;

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .ce            (ce),
        .stall         (stall),
        .flush         (flush),
        .pc_read_ready (pc_read_ready),
        .ibus_req      (ibus_req),
        .ibus_addr     (ibus_addr),
        .ibus_ack      (ibus_ack),
        .ibus_rdata    (ibus_rdata),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_valid      (if_valid),
        .if_excpt_adel (if_excpt_adel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Bus responder: acks ack_dly cycles after req rises.
    int          ack_dly = 0;
    int          wcnt = 0;
    logic        stray = 1'b0;
    logic [31:0] next_rdata = '0;

    always @(posedge clk) begin
        #2;
        ibus_ack   = 1'b0;
        ibus_rdata = '0;
        if (stray) begin
            ibus_ack   = 1'b1;
            ibus_rdata = 32'hbad0bad0;
        end else if (ibus_req && rst) begin
            if (wcnt >= ack_dly) begin
                ibus_ack   = 1'b1;
                ibus_rdata = next_rdata;
                wcnt       = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor
    logic        stall_q = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;
    int          rr_cnt = 0;
    int          req_cnt = 0;
    int          low_cnt = 0;
    int          last_gap = -1;

    always @(posedge clk) stall_q = stall;

    always @(negedge clk) begin
        exp_t e;
        if (pc_read_ready) rr_cnt++;
        if (ibus_req) begin
            if (!prev_req) begin
                req_cnt++;
                last_gap = low_cnt;
            end
            low_cnt = 0;
        end else begin
            low_cnt++;
        end
        if (rst && prev_req && !prev_ack) begin
            check_eq("req_held", ibus_req, 1);
            check_eq("addr_held", ibus_addr, prev_addr);
        end
        if (if_valid && !stall_q) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_word", if_valid, 0);
            end else begin
                e = sb.pop_front();
                check_eq("if_pc", if_pc, e.pc);
                check_eq("if_inst", if_inst, e.inst);
                check_eq("if_adel", if_excpt_adel, e.adel);
            end
        end
        prev_req  = ibus_req;
        prev_ack  = ibus_ack;
        prev_addr = ibus_addr;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input int dly);
        exp_t e;
        bit got;
        got        = 1'b0;
        pc         = a;
        ce         = 1'b1;
        next_rdata = d;
        ack_dly    = dly;
        e.pc       = a;
        e.adel     = (a[1:0] != 2'b00);
        e.inst     = e.adel ? 32'h0 : d;
        sb.push_back(e);
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (pc_read_ready) got = 1'b1;
        end
        check_eq("rr_seen", got, 1);
        @(posedge clk);
        #1 ce = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int q0;
        rst = 1'b0;
        pc  = 32'hbfc00002;
        ce  = 1'b1;
        @(negedge clk);
        check_eq("rst_req", ibus_req, 0);
        check_eq("rst_addr", ibus_addr, 0);
        check_eq("rst_pc", if_pc, 0);
        check_eq("rst_inst", if_inst, 0);
        check_eq("rst_valid", if_valid, 0);
        check_eq("rst_adel", if_excpt_adel, 0);
        check_eq("rst_rr", pc_read_ready, 0);
        @(posedge clk);
        #1;
        ce  = 1'b0;
        pc  = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic fetch
        r0 = rr_cnt;
        issue(32'hbfc00000, 32'h3c011234, 0);
        check_eq("t1_rr_cnt", rr_cnt - r0, 1);
        repeat (2) @(posedge clk);
        #1;

        // Stall across ack
        q0 = req_cnt;
        pc = 32'hbfc00004;
        ce = 1'b1;
        next_rdata = 32'h24210001;
        ack_dly = 0;
        sb.push_back('{pc: 32'hbfc00004, inst: 32'h24210001, adel: 1'b0});
        @(posedge clk);
        #1 stall = 1'b1;
        @(negedge clk);
        check_eq("rr_ack_stalled", pc_read_ready, 1);
        @(posedge clk);
        #1 ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("frozen_valid", if_valid, 0);
            check_eq("frozen_pc", if_pc, 32'hbfc00000);
            check_eq("hold_no_req", ibus_req, 0);
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("hold_release", if_valid, 1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("hold_req_cnt", req_cnt - q0, 1);

        // Flush while request pending
        r0 = rr_cnt;
        pc = 32'hbfc00008;
        ce = 1'b1;
        next_rdata = 32'hdeadbeef;
        ack_dly = 3;
        @(posedge clk);
        #1;
        flush = 1'b1;
        ce = 1'b0;
        @(negedge clk);
        check_eq("rr_flush", pc_read_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("flush_rr_cnt", rr_cnt - r0, 0);
        check_eq("flush_valid", if_valid, 0);
        check_eq("discard_done", ibus_req, 0);

        // Flush coincident with ack
        r0 = rr_cnt;
        pc = 32'hbfc0000c;
        ce = 1'b1;
        next_rdata = 32'h11112222;
        ack_dly = 0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        ce = 1'b0;
        @(negedge clk);
        check_eq("rr_flush_ack", pc_read_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_eq("flush_ack_req", ibus_req, 0);
        check_eq("flush_ack_valid", if_valid, 0);
        @(posedge clk);
        #1;

        // Misaligned fetch
        q0 = req_cnt;
        issue(32'hbfc00002, 32'h0, 0);
        @(negedge clk);
        check_eq("adel_set", if_excpt_adel, 1);
        check_eq("adel_no_req", req_cnt - q0, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("adel_drop", if_excpt_adel, 0);
        @(posedge clk);
        #1;

        // Back-to-back
        issue(32'hbfc00000, 32'h3c011234, 0);
        issue(32'hbfc00004, 32'h24210001, 0);
        check_eq("b2b_gap", last_gap, 1);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-request
        pc = 32'hbfc00010;
        ce = 1'b1;
        next_rdata = 32'h55555555;
        ack_dly = 5;
        @(posedge clk);
        #1 ce = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("arst_req", ibus_req, 0);
        check_eq("arst_addr", ibus_addr, 0);
        check_eq("arst_pc", if_pc, 0);
        check_eq("arst_inst", if_inst, 0);
        check_eq("arst_valid", if_valid, 0);
        check_eq("arst_rr", pc_read_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("stray_req", ibus_req, 0);
        check_eq("stray_valid", if_valid, 0);

        check_eq("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clk  input  1  sole clock; all state on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 pc  input  32  fetch address from PC register.
REQ-004 ce  input  1  fetch enable from PC register; 0 = no fetch.
REQ-005 stall  input  1  IF-stage stall from CTRL.
REQ-006 flush  input  1  pipeline flush from CTRL (exception).
REQ-007 pc_read_ready  output  1  pulse: current pc fetched, PC register may advance.
REQ-008 ibus_req  output  1  instruction-bus request.
REQ-009 ibus_addr  output  32  instruction-bus word address.
REQ-010 ibus_ack  input  1  one-cycle bus completion; ibus_rdata valid with it.
REQ-011 ibus_rdata  input  32  instruction word.
REQ-012 if_pc  output  32  PC of presented instruction.
REQ-013 if_inst  output  32  presented instruction.
REQ-014 if_valid  output  1  if_pc/if_inst hold a live instruction.
REQ-015 if_excpt_adel  output  1  presented slot is a misaligned-fetch exception.

Function
REQ-016 FSM states SHALL be IDLE, REQ, HOLD, DISCARD.
REQ-017 IDLE: when ce=1, stall=0, flush=0, pc[1:0]=0 -> REQ next cycle, latching ibus_addr=pc; ibus_req=1 registered from that edge.
REQ-018 IDLE with ce=1, stall=0, flush=0, pc[1:0]!=0 -> no bus request; next cycle if_valid=1, if_excpt_adel=1, if_pc=pc, if_inst=0; pc_read_ready=1 in the decision cycle.
REQ-019 REQ: ibus_req and ibus_addr SHALL stay stable until ibus_ack sampled high.
REQ-020 REQ, ibus_ack=1, flush=0: pc_read_ready=1 combinationally that cycle; stall=0 -> next cycle if_inst=ibus_rdata, if_pc=ibus_addr, if_valid=1, state IDLE; stall=1 -> word into hold buffer, state HOLD, outputs unchanged.
REQ-021 HOLD: no bus activity; when stall=0, buffer presented next cycle with if_valid=1, state IDLE.
REQ-022 Outputs if_* SHALL hold their values while stall=1; when stall=0 and no new word presented, if_valid SHALL drop to 0 next cycle.
REQ-023 flush=1 in any state: if_valid, if_excpt_adel, hold buffer cleared next cycle; pc_read_ready=0 that cycle.
REQ-024 flush=1 in REQ with ibus_ack=0 -> DISCARD; ibus_req stays high until ack; acked word dropped; DISCARD -> IDLE on ack.
REQ-025 flush=1 in REQ coincident with ibus_ack=1 -> word dropped, IDLE, no pc_read_ready.
REQ-026 At most one bus request outstanding; new request never issued in cycle of ack (min 1 idle cycle between requests).
REQ-027 Latency: pc stable at edge N -> ibus_req high after N; with ack in cycle N+1, if_valid high after edge N+2.

Reset
REQ-028 rst=0 SHALL asynchronously force: state IDLE, ibus_req=0, ibus_addr=0, if_pc=0, if_inst=0, if_valid=0, if_excpt_adel=0, buffer cleared; pc_read_ready=0 during reset.
REQ-029 Reset mid-request SHALL abandon the transaction; an ack arriving after reset release while in IDLE SHALL be ignored.

Structure
REQ-030 State encodings, ZeroWord and bus widths SHALL live in shared defines.v.
REQ-031 Single module; no sub-module.

Verification
REQ-032 Release reset, pc=0xbfc00000, ce=1, ack one cycle after req with rdata=0x3c011234 -> pc_read_ready pulse, if_pc=0xbfc00000, if_inst=0x3c011234, if_valid=1.
REQ-033 stall=1 across ack with rdata=0x24210001 -> outputs frozen, state HOLD; stall release -> word presented next cycle, no extra bus request.
REQ-034 flush while req pending, ack 3 cycles later with rdata=0xdeadbeef -> if_valid=0, 0xdeadbeef never presented, no pc_read_ready.
REQ-035 pc=0xbfc00002 -> no ibus_req, if_excpt_adel=1, if_pc=0xbfc00002, pc_read_ready pulse.
REQ-036 rst=0 asserted while ibus_req=1 -> all outputs zero immediately (async), stray ack after release ignored.
REQ-037 Back-to-back fetch 0xbfc00000, 0xbfc00004 with immediate acks -> two valid words, one idle cycle between requests.
